// File: rtl/bcd_scheduler.sv
// Round-robin scheduler sharing one binary-to-BCD converter between four channels.
// Handshake: a channel holds req high until its ack pulse; conv_start/conv_done frame one converter job.
module bcd_scheduler #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [55:0] val_flat,
  output logic        conv_start,
  output logic [13:0] conv_num,
  input  logic        conv_done,
  input  logic [15:0] conv_digits,
  output logic [3:0]  grant,
  output logic [3:0]  ack,
  output logic [15:0] res_digits,
  output logic [1:0]  res_ch,
  output logic        res_valid,
  output logic        sat,
  output logic        err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state, state_nxt;
  logic [1:0]  last_ch;
  logic [1:0]  owner;
  logic [7:0]  cnt;
  logic        job_sat;
  logic [3:0]  req_m;
  logic        win_found;
  logic [1:0]  win_ch;
  logic [1:0]  idx;
  logic [13:0] win_val;
  logic        timeout;

  // The channel just acked is masked for the idle cycle so it cannot re-win on its stale req.
  always_comb begin
    req_m     = req & ~ack;
    win_found = 1'b0;
    win_ch    = last_ch;
    idx       = last_ch;
    for (int i = 1; i <= 4; i++) begin
      idx = last_ch + 2'(i);
      if (!win_found && req_m[idx]) begin
        win_found = 1'b1;
        win_ch    = idx;
      end
    end
  end

  always_comb begin
    win_val = val_flat[13:0];
    case (win_ch)
      2'd0: win_val = val_flat[13:0];
      2'd1: win_val = val_flat[27:14];
      2'd2: win_val = val_flat[41:28];
      2'd3: win_val = val_flat[55:42];
      default: win_val = val_flat[13:0];
    endcase
  end

  // cnt equals cycles elapsed since conv_start, so the abort lands TIMEOUT cycles after it.
  assign timeout = (cnt == 8'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (win_found) state_nxt = BUSY;
      BUSY: if (conv_done || timeout) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_ch    <= 2'd3;
      owner      <= 2'd0;
      cnt        <= 8'd0;
      job_sat    <= 1'b0;
      grant      <= 4'd0;
      ack        <= 4'd0;
      conv_start <= 1'b0;
      conv_num   <= 14'd0;
      res_digits <= 16'd0;
      res_ch     <= 2'd0;
      res_valid  <= 1'b0;
      sat        <= 1'b0;
      err        <= 1'b0;
    end else begin
      conv_start <= 1'b0;
      ack        <= 4'd0;
      res_valid  <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          if (win_found) begin
            grant      <= 4'b0001 << win_ch;
            owner      <= win_ch;
            last_ch    <= win_ch;
            conv_start <= 1'b1;
            cnt        <= 8'd0;
            if (win_val > 14'd9999) begin
              conv_num <= 14'd9999;
              job_sat  <= 1'b1;
            end else begin
              conv_num <= win_val;
              job_sat  <= 1'b0;
            end
          end
        end
        BUSY: begin
          cnt <= cnt + 8'd1;
          if (conv_done) begin
            res_digits <= conv_digits;
            res_ch     <= owner;
            res_valid  <= 1'b1;
            sat        <= job_sat;
            ack        <= grant;
            grant      <= 4'd0;
          end else if (timeout) begin
            err   <= 1'b1;
            ack   <= grant;
            grant <= 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_scheduler.sv
// Directed bench for bcd_scheduler: arbitration order, clamping, completion, timeout and reset abort.
module tb_bcd_scheduler;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [55:0] val_flat;
  logic        conv_start;
  logic [13:0] conv_num;
  logic        conv_done;
  logic [15:0] conv_digits;
  logic [3:0]  grant;
  logic [3:0]  ack;
  logic [15:0] res_digits;
  logic [1:0]  res_ch;
  logic        res_valid;
  logic        sat;
  logic        err;

  int tests_run = 0;
  int tests_failed = 0;
  int bad;

  bcd_scheduler #(.TIMEOUT(64)) dut (
    .clk(clk), .rst(rst), .req(req), .val_flat(val_flat),
    .conv_start(conv_start), .conv_num(conv_num),
    .conv_done(conv_done), .conv_digits(conv_digits),
    .grant(grant), .ack(ack), .res_digits(res_digits), .res_ch(res_ch),
    .res_valid(res_valid), .sat(sat), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Outputs are observed 1 ns after the active edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_val(input int ch, input logic [13:0] v);
    val_flat[14*ch +: 14] = v;
  endtask

  initial begin
    rst = 1'b1; req = 4'd0; val_flat = 56'd0; conv_done = 1'b0; conv_digits = 16'd0;
    tick(); tick();
    rst = 1'b0;
    check("rst grant", 32'(grant), 32'h0);
    check("rst ack", 32'(ack), 32'h0);
    check("rst conv_start", 32'(conv_start), 32'h0);
    check("rst conv_num", 32'(conv_num), 32'h0);
    check("rst res_digits", 32'(res_digits), 32'h0);
    check("rst res_ch", 32'(res_ch), 32'h0);
    check("rst flags", 32'({res_valid, sat, err}), 32'h0);

    // Single job on channel 0, converter answers 37 cycles after start
    tick();
    set_val(0, 14'd1234);
    req = 4'b0001;
    tick();
    check("j1 grant", 32'(grant), 32'h1);
    check("j1 conv_start", 32'(conv_start), 32'h1);
    check("j1 conv_num", 32'(conv_num), 32'd1234);
    tick();
    check("j1 start one cycle", 32'(conv_start), 32'h0);
    repeat (36) tick();
    conv_done = 1'b1; conv_digits = 16'h1234;
    tick();
    conv_done = 1'b0;
    check("j1 res_valid", 32'(res_valid), 32'h1);
    check("j1 ack", 32'(ack), 32'h1);
    check("j1 res_digits", 32'(res_digits), 32'h1234);
    check("j1 res_ch", 32'(res_ch), 32'h0);
    check("j1 sat", 32'(sat), 32'h0);
    check("j1 grant idle", 32'(grant), 32'h0);
    req = 4'b0000;
    tick();
    check("j1 pulses end", 32'({res_valid, ack}), 32'h0);
    check("j1 res held", 32'(res_digits), 32'h1234);

    // All channels requesting after reset: order 0,1,2,3,0 with one idle cycle between jobs
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int n = 0; n < 4; n++) set_val(n, 14'(100 * n + 7));
    req = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      tick();
      check($sformatf("rr%0d grant", j), 32'(grant), 32'(4'b0001 << (j % 4)));
      check($sformatf("rr%0d conv_num", j), 32'(conv_num), 32'(100 * (j % 4) + 7));
      repeat (3) tick();
      conv_done = 1'b1; conv_digits = 16'(16'h1000 + j);
      tick();
      conv_done = 1'b0;
      check($sformatf("rr%0d ack", j), 32'(ack), 32'(4'b0001 << (j % 4)));
      check($sformatf("rr%0d idle grant", j), 32'(grant), 32'h0);
      check($sformatf("rr%0d res_ch", j), 32'(res_ch), 32'(j % 4));
      check($sformatf("rr%0d res_digits", j), 32'(res_digits), 32'(16'h1000 + j));
    end
    req = 4'b0000;

    // Clamp on channel 2; req and value changes while busy must not disturb the job
    tick();
    set_val(2, 14'd16383);
    req = 4'b0100;
    tick();
    check("clamp grant", 32'(grant), 32'h4);
    check("clamp conv_num", 32'(conv_num), 32'd9999);
    req = 4'b1011;
    set_val(2, 14'd5);
    tick();
    check("busy conv_num stable", 32'(conv_num), 32'd9999);
    check("busy grant stable", 32'(grant), 32'h4);
    req = 4'b0100;
    repeat (4) tick();
    conv_done = 1'b1; conv_digits = 16'h9999;
    tick();
    conv_done = 1'b0;
    check("clamp res_valid", 32'(res_valid), 32'h1);
    check("clamp sat", 32'(sat), 32'h1);
    check("clamp ack", 32'(ack), 32'h4);
    check("clamp res_ch", 32'(res_ch), 32'h2);
    req = 4'b0000;

    // 9999 itself is passed through without saturation
    tick();
    set_val(3, 14'd9999);
    req = 4'b1000;
    tick();
    check("edge grant", 32'(grant), 32'h8);
    check("edge conv_num", 32'(conv_num), 32'd9999);
    repeat (2) tick();
    conv_done = 1'b1; conv_digits = 16'h9998;
    tick();
    conv_done = 1'b0;
    check("edge sat", 32'(sat), 32'h0);
    check("edge res_digits", 32'(res_digits), 32'h9998);
    req = 4'b0000;

    // Converter never answers: abort 64 cycles after conv_start
    tick();
    set_val(1, 14'd42);
    req = 4'b0010;
    tick();
    check("to grant", 32'(grant), 32'h2);
    check("to conv_start", 32'(conv_start), 32'h1);
    bad = 0;
    repeat (63) begin
      tick();
      if (err || ack != 4'd0 || res_valid) bad++;
    end
    check("to no early abort", 32'(bad), 32'h0);
    tick();
    check("to err", 32'(err), 32'h1);
    check("to ack", 32'(ack), 32'h2);
    check("to res_valid", 32'(res_valid), 32'h0);
    check("to res_digits kept", 32'(res_digits), 32'h9998);
    check("to res_ch kept", 32'(res_ch), 32'h3);
    check("to grant idle", 32'(grant), 32'h0);
    req = 4'b0000;
    tick();
    check("to err one cycle", 32'(err), 32'h0);

    // Done in the same cycle as the timeout: done wins
    set_val(3, 14'd77);
    req = 4'b1000;
    tick();
    check("co grant", 32'(grant), 32'h8);
    repeat (63) tick();
    conv_done = 1'b1; conv_digits = 16'h4321;
    tick();
    conv_done = 1'b0;
    check("co res_valid", 32'(res_valid), 32'h1);
    check("co err", 32'(err), 32'h0);
    check("co ack", 32'(ack), 32'h8);
    check("co res_digits", 32'(res_digits), 32'h4321);
    req = 4'b0000;
    tick();
    check("co no late err", 32'(err), 32'h0);

    // Reset in the middle of a job, then a late conv_done while idle
    req = 4'b0001;
    tick();
    check("ra grant", 32'(grant), 32'h1);
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    req = 4'b0000;
    check("ra grant", 32'(grant), 32'h0);
    check("ra ack", 32'(ack), 32'h0);
    check("ra conv_num", 32'(conv_num), 32'h0);
    check("ra res_digits", 32'(res_digits), 32'h0);
    check("ra flags", 32'({conv_start, res_valid, sat, err, res_ch}), 32'h0);
    conv_done = 1'b1; conv_digits = 16'h5555;
    tick();
    conv_done = 1'b0;
    check("late done res_valid", 32'(res_valid), 32'h0);
    check("late done res_digits", 32'(res_digits), 32'h0);
    check("late done ack", 32'(ack), 32'h0);
    tick();
    check("late done grant", 32'({grant, conv_start}), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
